io_supply_seq: RTL and testbench



---
 rtl/io_seq_pkg.sv | 65 ++++++
 rtl/sync_2ff.sv | 21 ++
 rtl/io_supply_seq.sv | 114 +++++++++++
 tb/tb_io_supply_seq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_seq_pkg.sv
// Shared types for the IO ring supply sequencer: state encoding, pad-control
// output bundle, its OFF values and the state-to-output decode.
package io_seq_pkg;

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_DEBOUNCE = 3'd1,
      S_BIAS     = 3'd2,
      S_RELEASE  = 3'd3,
      S_READY    = 3'd4,
      S_PD_OE    = 3'd5,
      S_PD_HOLD  = 3'd6,
      S_PDOWN    = 3'd7
   } io_seq_state_e;

   typedef struct packed {
      logic bias_en;
      logic pad_hold;
      logic pad_oe_en;
      logic io_ready;
      logic pd_ack;
   } io_seq_out_t;

   localparam io_seq_out_t OFF_OUT = '{
      bias_en:   1'b0,
      pad_hold:  1'b1,
      pad_oe_en: 1'b0,
      io_ready:  1'b0,
      pd_ack:    1'b0
   };

   // Pad-control values implied by each state.
   function automatic io_seq_out_t decode_out(input io_seq_state_e s);
      io_seq_out_t o;
      o = OFF_OUT;
      case (s)
         S_BIAS: begin
            o.bias_en = 1'b1;
         end
         S_RELEASE: begin
            o.bias_en  = 1'b1;
            o.pad_hold = 1'b0;
         end
         S_READY: begin
            o.bias_en   = 1'b1;
            o.pad_hold  = 1'b0;
            o.pad_oe_en = 1'b1;
            o.io_ready  = 1'b1;
         end
         S_PD_OE: begin
            o.bias_en  = 1'b1;
            o.pad_hold = 1'b0;
         end
         S_PD_HOLD: begin
            o.bias_en = 1'b1;
         end
         S_PDOWN: begin
            o.pd_ack = 1'b1;
         end
         default: o = OFF_OUT;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/io_supply_seq.sv
// IO ring power sequencer: debounces the supply-good flags, then releases
// bias, hold and output enable in order; reverses on loss or power-down request.
module io_supply_seq #(
   parameter int unsigned DEBOUNCE_CYC  = 64,
   parameter int unsigned BIAS_WAIT_CYC = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vddio_ok_a,
   input  logic       vdd_ok_a,
   input  logic       pd_req,
   output logic       pd_ack,
   output logic       bias_en,
   output logic       pad_hold,
   output logic       pad_oe_en,
   output logic       io_ready,
   output logic       fault,
   output logic [2:0] state_o
);

   import io_seq_pkg::*;

   localparam int unsigned CNT_MAX = (DEBOUNCE_CYC > BIAS_WAIT_CYC) ? DEBOUNCE_CYC : BIAS_WAIT_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DEB_LOAD  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] BIAS_LOAD = CNT_W'(BIAS_WAIT_CYC - 1);

   logic vddio_ok_s;
   logic vdd_ok_s;
   logic supply_ok;

   io_seq_state_e    state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             fault_nxt;
   io_seq_out_t      outs, outs_nxt;

   sync_2ff u_sync_vddio (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (vddio_ok_a),
      .q     (vddio_ok_s)
   );

   sync_2ff u_sync_vdd (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (vdd_ok_a),
      .q     (vdd_ok_s)
   );

   assign supply_ok = vddio_ok_s & vdd_ok_s;

   // Next state, counter reload/decrement, fault and output decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fault_nxt = fault;

      case (state)
         S_OFF:      if (supply_ok) state_nxt = S_DEBOUNCE;
         S_DEBOUNCE: if (cnt == '0) state_nxt = S_BIAS;
         S_BIAS:     if (cnt == '0) state_nxt = S_RELEASE;
         S_RELEASE:  state_nxt = S_READY;
         S_READY:    if (pd_req) state_nxt = S_PD_OE;
         S_PD_OE:    state_nxt = S_PD_HOLD;
         S_PD_HOLD:  state_nxt = S_PDOWN;
         S_PDOWN:    if (!pd_req) state_nxt = S_OFF;
         default:    state_nxt = S_OFF;
      endcase

      // Supply loss overrides both the request and the counter.
      if (state != S_OFF && !supply_ok) state_nxt = S_OFF;

      if (state == S_READY && !supply_ok) begin
         fault_nxt = 1'b1;
      end else if (state_nxt == S_PDOWN && state != S_PDOWN) begin
         fault_nxt = 1'b0;
      end

      if (state_nxt != state) begin
         case (state_nxt)
            S_DEBOUNCE: cnt_nxt = DEB_LOAD;
            S_BIAS:     cnt_nxt = BIAS_LOAD;
            default:    cnt_nxt = '0;
         endcase
      end else if (cnt != '0) begin
         cnt_nxt = cnt - CNT_W'(1);
      end

      outs_nxt = decode_out(state_nxt);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_OFF;
         cnt   <= '0;
         fault <= 1'b0;
         outs  <= OFF_OUT;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         fault <= fault_nxt;
         outs  <= outs_nxt;
      end
   end

   assign bias_en   = outs.bias_en;
   assign pad_hold  = outs.pad_hold;
   assign pad_oe_en = outs.pad_oe_en;
   assign io_ready  = outs.io_ready;
   assign pd_ack    = outs.pd_ack;
   assign state_o   = state;

endmodule

// File: tb/tb_io_supply_seq.sv
// Bench for io_supply_seq: directed sequencing scenarios plus a randomized run
// checked against a phase/elapsed-time model of the sequencer.
module tb_io_supply_seq;

   localparam int D = 4;
   localparam int B = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vddio_ok_a = 1'b0;
   logic       vdd_ok_a = 1'b0;
   logic       pd_req = 1'b0;
   logic       pd_ack, bias_en, pad_hold, pad_oe_en, io_ready, fault;
   logic [2:0] state_o;

   int checks = 0;
   int failures = 0;

   // Model: sync pipes, mode (0 off, 1 powering up/ready, 2 powering down),
   // elapsed cycles in the up phase, step index in the down phase, fault.
   logic m_s1a = 1'b0, m_s2a = 1'b0, m_s1b = 1'b0, m_s2b = 1'b0;
   int   m_mode = 0;
   int   m_up = 0;
   int   m_pd = 0;
   logic m_fault = 1'b0;

   io_supply_seq #(.DEBOUNCE_CYC(D), .BIAS_WAIT_CYC(B)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vddio_ok_a (vddio_ok_a),
      .vdd_ok_a   (vdd_ok_a),
      .pd_req     (pd_req),
      .pd_ack     (pd_ack),
      .bias_en    (bias_en),
      .pad_hold   (pad_hold),
      .pad_oe_en  (pad_oe_en),
      .io_ready   (io_ready),
      .fault      (fault),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // {state, bias, hold, oe, ready, ack}
   function automatic logic [7:0] dut_vec();
      return {state_o, bias_en, pad_hold, pad_oe_en, io_ready, pd_ack};
   endfunction

   function automatic logic [7:0] m_vec();
      if (m_mode == 1) begin
         if (m_up < D)          return 8'b001_01000;
         else if (m_up < D + B) return 8'b010_11000;
         else if (m_up == D + B) return 8'b011_10000;
         else                   return 8'b100_10110;
      end else if (m_mode == 2) begin
         if (m_pd == 1)      return 8'b101_10000;
         else if (m_pd == 2) return 8'b110_11000;
         else                return 8'b111_01001;
      end
      return 8'b000_01000;
   endfunction

   task automatic model_update();
      logic sup;
      if (!rst_n) begin
         m_s1a = 1'b0; m_s2a = 1'b0; m_s1b = 1'b0; m_s2b = 1'b0;
         m_mode = 0; m_up = 0; m_pd = 0; m_fault = 1'b0;
      end else begin
         sup = m_s2a & m_s2b;
         if (m_mode == 0) begin
            if (sup) begin m_mode = 1; m_up = 0; end
         end else if (m_mode == 1) begin
            if (!sup) begin
               if (m_up == D + B + 1) m_fault = 1'b1;
               m_mode = 0;
            end else if (m_up == D + B + 1) begin
               if (pd_req) begin m_mode = 2; m_pd = 1; end
            end else begin
               m_up++;
            end
         end else begin
            if (!sup) m_mode = 0;
            else if (m_pd < 3) begin
               m_pd++;
               if (m_pd == 3) m_fault = 1'b0;
            end else if (!pd_req) m_mode = 0;
         end
         m_s2a = m_s1a; m_s1a = vddio_ok_a;
         m_s2b = m_s1b; m_s1b = vdd_ok_a;
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; vddio_ok_a = 1'b0; vdd_ok_a = 1'b0; pd_req = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic power_up_to_ready();
      do_reset();
      vddio_ok_a = 1'b1; vdd_ok_a = 1'b1;
      repeat (D + B + 4) step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({dut_vec(), fault} !== {8'b000_01000, 1'b0}) begin
         failures++;
         $display("FAIL reset_values: got %b fault=%b, want 00001000 fault=0", dut_vec(), fault);
      end
   endtask

   task automatic test_power_up();
      int t_bias = -1, t_hold = -1, t_rdy = -1, t_oe = -1;
      logic saw_fault = 1'b0;
      do_reset();
      vddio_ok_a = 1'b1; vdd_ok_a = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         step();
         if (bias_en && t_bias < 0) t_bias = i;
         if (!pad_hold && t_hold < 0) t_hold = i;
         if (io_ready && t_rdy < 0) t_rdy = i;
         if (pad_oe_en && t_oe < 0) t_oe = i;
         if (fault) saw_fault = 1'b1;
      end
      checks++;
      if (t_bias !== 7) begin failures++; $display("FAIL pwrup_bias_time: got %0d want 7", t_bias); end
      checks++;
      if (t_hold !== 9) begin failures++; $display("FAIL pwrup_hold_time: got %0d want 9", t_hold); end
      checks++;
      if (t_rdy !== 10) begin failures++; $display("FAIL pwrup_ready_time: got %0d want 10", t_rdy); end
      checks++;
      if (t_oe !== 10) begin failures++; $display("FAIL pwrup_oe_time: got %0d want 10", t_oe); end
      checks++;
      if (saw_fault !== 1'b0) begin failures++; $display("FAIL pwrup_fault: got 1 want 0"); end
   endtask

   task automatic test_glitch();
      logic early_bias = 1'b0;
      int t_rdy = -1;
      do_reset();
      vddio_ok_a = 1'b1; vdd_ok_a = 1'b1;
      repeat (4) step();
      vdd_ok_a = 1'b0;
      step();
      vdd_ok_a = 1'b1;
      step(); step();
      checks++;
      if (state_o !== 3'd0 || bias_en !== 1'b0) begin
         failures++;
         $display("FAIL glitch_to_off: got state=%0d bias=%b want state=0 bias=0", state_o, bias_en);
      end
      for (int i = 3; i <= 14; i++) begin
         step();
         if (bias_en && i < 7) early_bias = 1'b1;
         if (io_ready && t_rdy < 0) t_rdy = i;
      end
      checks++;
      if (early_bias !== 1'b0) begin failures++; $display("FAIL glitch_bias_early: got 1 want 0"); end
      checks++;
      if (t_rdy !== 10) begin failures++; $display("FAIL glitch_ready_time: got %0d want 10", t_rdy); end
   endtask

   task automatic test_pd_handshake();
      int t_rdy = -1;
      power_up_to_ready();
      checks++;
      if (io_ready !== 1'b1) begin failures++; $display("FAIL pd_pre_ready: got %b want 1", io_ready); end
      pd_req = 1'b1;
      step();
      checks++;
      if ({pad_oe_en, pad_hold, bias_en, pd_ack} !== 4'b0010) begin
         failures++; $display("FAIL pd_step1: got oe,hold,bias,ack=%b want 0010", {pad_oe_en, pad_hold, bias_en, pd_ack});
      end
      step();
      checks++;
      if ({pad_oe_en, pad_hold, bias_en, pd_ack} !== 4'b0110) begin
         failures++; $display("FAIL pd_step2: got oe,hold,bias,ack=%b want 0110", {pad_oe_en, pad_hold, bias_en, pd_ack});
      end
      step();
      checks++;
      if ({state_o, pad_hold, bias_en, pd_ack} !== 6'b111_101) begin
         failures++; $display("FAIL pd_step3: got state,hold,bias,ack=%b want 111101", {state_o, pad_hold, bias_en, pd_ack});
      end
      step(); step();
      checks++;
      if (pd_ack !== 1'b1) begin failures++; $display("FAIL pd_ack_held: got %b want 1", pd_ack); end
      pd_req = 1'b0;
      step();
      checks++;
      if ({state_o, pd_ack} !== 4'b000_0) begin
         failures++; $display("FAIL pd_release: got state=%0d ack=%b want state=0 ack=0", state_o, pd_ack);
      end
      for (int i = 1; i <= 12; i++) begin
         step();
         if (io_ready && t_rdy < 0) t_rdy = i;
      end
      checks++;
      if (t_rdy !== D + B + 2) begin failures++; $display("FAIL pd_repower_time: got %0d want %0d", t_rdy, D + B + 2); end
   endtask

   task automatic test_supply_loss();
      int t_rdy = -1;
      power_up_to_ready();
      vddio_ok_a = 1'b0;
      step(); step();
      checks++;
      if (io_ready !== 1'b1) begin failures++; $display("FAIL loss_early: got ready=%b want 1", io_ready); end
      step();
      checks++;
      if ({pad_hold, pad_oe_en, io_ready, fault, state_o} !== 7'b1001_000) begin
         failures++; $display("FAIL loss_response: got hold,oe,rdy,fault,state=%b want 1001000",
                              {pad_hold, pad_oe_en, io_ready, fault, state_o});
      end
      vddio_ok_a = 1'b1;
      for (int i = 1; i <= 20 && t_rdy < 0; i++) begin
         step();
         if (io_ready) t_rdy = i;
      end
      checks++;
      if (t_rdy !== 10 || fault !== 1'b1) begin
         failures++; $display("FAIL loss_repower: got ready_time=%0d fault=%b want 10 and 1", t_rdy, fault);
      end
      pd_req = 1'b1;
      repeat (3) step();
      checks++;
      if ({fault, pd_ack} !== 2'b01) begin
         failures++; $display("FAIL loss_fault_clear: got fault,ack=%b want 01", {fault, pd_ack});
      end
      pd_req = 1'b0;
      step();
   endtask

   task automatic test_simultaneous();
      logic saw_ack = 1'b0, saw_pd = 1'b0;
      power_up_to_ready();
      vddio_ok_a = 1'b0;
      step(); step();
      pd_req = 1'b1;
      step();
      checks++;
      if ({state_o, fault, pad_oe_en, pad_hold} !== 6'b000_101) begin
         failures++; $display("FAIL simul_off: got state,fault,oe,hold=%b want 000101", {state_o, fault, pad_oe_en, pad_hold});
      end
      repeat (10) begin
         step();
         if (pd_ack) saw_ack = 1'b1;
         if (state_o >= 3'd5) saw_pd = 1'b1;
      end
      checks++;
      if ({saw_ack, saw_pd} !== 2'b00) begin
         failures++; $display("FAIL simul_no_pd: got ack_seen,pd_seen=%b want 00", {saw_ack, saw_pd});
      end
      pd_req = 1'b0;
      vddio_ok_a = 1'b1;
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      vddio_ok_a = 1'b1; vdd_ok_a = 1'b1;
      repeat (7) step();
      checks++;
      if ({state_o, bias_en} !== 4'b010_1) begin
         failures++; $display("FAIL rstmid_in_bias: got state=%0d bias=%b want 2 and 1", state_o, bias_en);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if ({dut_vec(), fault} !== {8'b000_01000, 1'b0}) begin
         failures++; $display("FAIL rstmid_values: got %b fault=%b want 00001000 fault=0", dut_vec(), fault);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      int reached_ready = 0;
      int errs_here = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) vddio_ok_a = ~vddio_ok_a;
         if ($urandom_range(0, 39) == 0) vdd_ok_a = ~vdd_ok_a;
         if ($urandom_range(0, 15) == 0) pd_req = ~pd_req;
         rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
         step();
         if (io_ready) reached_ready++;
         checks++;
         if ({dut_vec(), fault} !== {m_vec(), m_fault}) begin
            failures++;
            errs_here++;
            if (errs_here <= 10)
               $display("FAIL random_cycle%0d: got vec=%b fault=%b want vec=%b fault=%b",
                        i, dut_vec(), fault, m_vec(), m_fault);
         end
      end
      rst_n = 1'b1;
      pd_req = 1'b0;
      checks++;
      if (reached_ready == 0) begin
         failures++; $display("FAIL random_coverage: got ready cycles=0 want >0");
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_glitch();
      test_pd_handshake();
      test_supply_loss();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
